// File: rtl/sd_pkg.sv
// Shared definitions for the SD bus sequencer: FSM encodings, default idle-clock
// counts and client identifiers.
package sd_pkg;

    localparam logic [2:0] S_POWERUP    = 3'd0;
    localparam logic [2:0] S_INIT_START = 3'd1;
    localparam logic [2:0] S_INIT_RUN   = 3'd2;
    localparam logic [2:0] S_IDLE       = 3'd3;
    localparam logic [2:0] S_GRANT_WR   = 3'd4;
    localparam logic [2:0] S_GRANT_RD   = 3'd5;
    localparam logic [2:0] S_GAP        = 3'd6;
    localparam logic [2:0] S_ERROR      = 3'd7;

    localparam int POWERUP_CLKS_DEF = 80;
    localparam int GAP_CLKS_DEF     = 8;

    typedef enum logic [1:0] {
        CLIENT_INIT = 2'd0,
        CLIENT_WR   = 2'd1,
        CLIENT_RD   = 2'd2
    } client_e;

    // States in which a client owns CS and MOSI.
    function automatic logic is_bus_state(input logic [2:0] s);
        return (s == S_INIT_RUN) || (s == S_GRANT_WR) || (s == S_GRANT_RD);
    endfunction

endpackage

// File: rtl/sd_idle_clock_counter.sv
// Loadable saturating down-counter with a done flag (count == 0); used for the
// power-up clocks, the inter-transaction gap and the optional watchdog.
module sd_idle_clock_counter #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_s_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_s_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= RST_VAL;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/sd_bus_sequencer.sv
// Owns the SD card SPI link: power-up clocks, init hand-off, then fair WR/RD
// arbitration with idle gaps. Optional per-grant watchdog: SD_SEQ_TIMEOUT_EN.
module sd_bus_sequencer
    import sd_pkg::*;
#(
    parameter int POWERUP_CLKS = POWERUP_CLKS_DEF,
    parameter int GAP_CLKS     = GAP_CLKS_DEF
`ifdef SD_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1048576
`endif
) (
    input  logic       i_s_clk,
    input  logic       i_reset,
    input  logic       i_init_busy,
    input  logic       i_init_ok,
    input  logic       i_init_mosi,
    output logic       o_init_start,
    input  logic       i_wr_req,
    input  logic       i_wr_busy,
    input  logic       i_wr_mosi,
    output logic       o_wr_start,
    input  logic       i_rd_req,
    input  logic       i_rd_busy,
    input  logic       i_rd_mosi,
    output logic       o_rd_start,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_ready,
    output logic       o_error,
    output logic [2:0] o_3_state
);

    localparam int PU_W  = $clog2(POWERUP_CLKS + 1);
    localparam int GAP_W = $clog2(GAP_CLKS + 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic       r_arm;
    logic       r_init_done;
    client_e    r_last;

    logic       w_pu_done;
    logic       w_gap_done;
    logic       w_gap_load;
    logic       w_run_entry;
    logic       w_busy;
    logic       w_mosi_sel;
    logic       w_grant_wr;
    logic       w_timeout;

    // Only the owning client's busy/mosi are ever looked at.
    always_comb begin
        w_busy     = 1'b0;
        w_mosi_sel = 1'b1;
        case (r_state)
            S_INIT_RUN: begin
                w_busy     = i_init_busy;
                w_mosi_sel = i_init_mosi;
            end
            S_GRANT_WR: begin
                w_busy     = i_wr_busy;
                w_mosi_sel = i_wr_mosi;
            end
            S_GRANT_RD: begin
                w_busy     = i_rd_busy;
                w_mosi_sel = i_rd_mosi;
            end
            default: ;
        endcase
    end

    assign w_grant_wr = i_wr_req && (!i_rd_req || (r_last == CLIENT_RD));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_POWERUP:    if (w_pu_done) w_state_nxt = S_INIT_START;
            S_INIT_START: w_state_nxt = S_INIT_RUN;
            S_INIT_RUN:   if (!r_arm && !w_busy) w_state_nxt = i_init_ok ? S_GAP : S_ERROR;
            S_IDLE:       if (i_wr_req || i_rd_req) w_state_nxt = w_grant_wr ? S_GRANT_WR : S_GRANT_RD;
            S_GRANT_WR,
            S_GRANT_RD:   if (!r_arm && !w_busy) w_state_nxt = S_GAP;
            S_GAP:        if (w_gap_done) w_state_nxt = S_IDLE;
            default:      w_state_nxt = S_ERROR;
        endcase
        if (is_bus_state(r_state) && w_timeout) begin
            w_state_nxt = S_ERROR;
        end
    end

    assign w_run_entry = is_bus_state(w_state_nxt) && !is_bus_state(r_state);
    assign w_gap_load  = (w_state_nxt == S_GAP) && (r_state != S_GAP);

    always_ff @(posedge i_s_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_POWERUP;
            r_arm       <= 1'b0;
            r_init_done <= 1'b0;
            r_last      <= CLIENT_RD;
        end else begin
            r_state <= w_state_nxt;
            // Arm flag marks the first owned cycle, where busy is not yet meaningful.
            r_arm   <= w_run_entry;
            if ((r_state == S_INIT_RUN) && (w_state_nxt == S_GAP)) begin
                r_init_done <= 1'b1;
            end
            if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT_WR)) begin
                r_last <= CLIENT_WR;
            end else if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT_RD)) begin
                r_last <= CLIENT_RD;
            end
        end
    end

    sd_idle_clock_counter #(
        .W       (PU_W),
        .RST_VAL (PU_W'(POWERUP_CLKS - 1))
    ) u_powerup (
        .i_s_clk    (i_s_clk),
        .i_reset    (i_reset),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == S_POWERUP),
        .o_done     (w_pu_done)
    );

    sd_idle_clock_counter #(
        .W       (GAP_W),
        .RST_VAL ('0)
    ) u_gap (
        .i_s_clk    (i_s_clk),
        .i_reset    (i_reset),
        .i_load     (w_gap_load),
        .i_load_val (GAP_W'(GAP_CLKS - 1)),
        .i_en       (r_state == S_GAP),
        .o_done     (w_gap_done)
    );

`ifdef SD_SEQ_TIMEOUT_EN
    localparam int WD_W = 21;

    sd_idle_clock_counter #(
        .W       (WD_W),
        .RST_VAL ('0)
    ) u_watchdog (
        .i_s_clk    (i_s_clk),
        .i_reset    (i_reset),
        .i_load     (w_run_entry),
        .i_load_val (WD_W'(TIMEOUT_CYCLES - 1)),
        .i_en       (is_bus_state(r_state)),
        .o_done     (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    assign o_cs_n       = !is_bus_state(r_state);
    assign o_mosi       = w_mosi_sel;
    assign o_init_start = (r_state == S_INIT_START);
    assign o_wr_start   = (r_state == S_GRANT_WR) && r_arm;
    assign o_rd_start   = (r_state == S_GRANT_RD) && r_arm;
    assign o_ready      = (r_state == S_IDLE) && r_init_done;
    assign o_error      = (r_state == S_ERROR);
    assign o_3_state    = r_state;

endmodule

// File: tb/tb_sd_bus_sequencer.sv
// Directed-sequence bench with randomized lengths, requests and serial data,
// checked against a transaction-level model of the sequencer's rules.
module tb_sd_bus_sequencer;

    localparam int PU_CLKS = 80;
    localparam int GAP     = 8;
    localparam int C_INIT  = 0;
    localparam int C_WR    = 1;
    localparam int C_RD    = 2;

    logic       i_s_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_init_busy = 1'b0, i_init_ok = 1'b0, i_init_mosi = 1'b0;
    logic       i_wr_req = 1'b0, i_wr_busy = 1'b0, i_wr_mosi = 1'b0;
    logic       i_rd_req = 1'b0, i_rd_busy = 1'b0, i_rd_mosi = 1'b0;
    logic       o_init_start, o_wr_start, o_rd_start;
    logic       o_mosi, o_cs_n, o_ready, o_error;
    logic [2:0] o_3_state;

    int checks   = 0;
    int failures = 0;
    int last_srv = C_RD;

    always #5 i_s_clk = ~i_s_clk;

    sd_bus_sequencer dut (
        .i_s_clk      (i_s_clk),
        .i_reset      (i_reset),
        .i_init_busy  (i_init_busy),
        .i_init_ok    (i_init_ok),
        .i_init_mosi  (i_init_mosi),
        .o_init_start (o_init_start),
        .i_wr_req     (i_wr_req),
        .i_wr_busy    (i_wr_busy),
        .i_wr_mosi    (i_wr_mosi),
        .o_wr_start   (o_wr_start),
        .i_rd_req     (i_rd_req),
        .i_rd_busy    (i_rd_busy),
        .i_rd_mosi    (i_rd_mosi),
        .o_rd_start   (o_rd_start),
        .o_mosi       (o_mosi),
        .o_cs_n       (o_cs_n),
        .o_ready      (o_ready),
        .o_error      (o_error),
        .o_3_state    (o_3_state)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rand_mosi();
        i_init_mosi = 1'($urandom);
        i_wr_mosi   = 1'($urandom);
        i_rd_mosi   = 1'($urandom);
    endtask

    // One cycle in which no client owns the bus.
    task automatic quiet_cycle(input string tag, input logic [2:0] st, input logic rdy, input logic err);
        rand_mosi();
        #1;
        chk1({tag, ".cs_n"}, o_cs_n, 1'b1);
        chk1({tag, ".mosi"}, o_mosi, 1'b1);
        chk1({tag, ".init_start"}, o_init_start, 1'b0);
        chk1({tag, ".wr_start"}, o_wr_start, 1'b0);
        chk1({tag, ".rd_start"}, o_rd_start, 1'b0);
        chk1({tag, ".ready"}, o_ready, rdy);
        chk1({tag, ".error"}, o_error, err);
        chk3({tag, ".state"}, o_3_state, st);
        @(negedge i_s_clk);
    endtask

    task automatic apply_reset();
        i_reset = 1'b1;
        i_init_busy = 1'b0; i_init_ok = 1'b0; i_init_mosi = 1'b0;
        i_wr_req = 1'b0; i_wr_busy = 1'b0; i_wr_mosi = 1'b0;
        i_rd_req = 1'b0; i_rd_busy = 1'b0; i_rd_mosi = 1'b0;
        #1;
        chk1("reset.cs_n", o_cs_n, 1'b1);
        chk1("reset.mosi", o_mosi, 1'b1);
        chk1("reset.init_start", o_init_start, 1'b0);
        chk1("reset.wr_start", o_wr_start, 1'b0);
        chk1("reset.rd_start", o_rd_start, 1'b0);
        chk1("reset.ready", o_ready, 1'b0);
        chk1("reset.error", o_error, 1'b0);
        chk3("reset.state", o_3_state, 3'd0);
        @(negedge i_s_clk);
        @(negedge i_s_clk);
        i_reset  = 1'b0;
        last_srv = C_RD;
    endtask

    task automatic powerup_check();
        for (int i = 0; i < PU_CLKS; i++) quiet_cycle("powerup", 3'd0, 1'b0, 1'b0);
    endtask

    // Client c owns the bus; its busy is high for owned cycles 1..len-1. The first
    // owned cycle ignores busy, so an owned period lasts at least two cycles.
    task automatic do_txn(input int c, input int len, input logic ok, input int rd_raise_at,
                          input bit shuffle_reqs);
        int         blen;
        logic       exp_mosi;
        logic [2:0] st;
        blen = (len < 2) ? 2 : len;
        st   = (c == C_INIT) ? 3'd2 : ((c == C_WR) ? 3'd4 : 3'd5);
        if (c == C_INIT) begin
            rand_mosi();
            i_init_busy = (len > 1);
            #1;
            chk1("init_start.pulse", o_init_start, 1'b1);
            chk3("init_start.state", o_3_state, 3'd1);
            chk1("init_start.cs_n", o_cs_n, 1'b1);
            chk1("init_start.mosi", o_mosi, 1'b1);
            chk1("init_start.wr_start", o_wr_start, 1'b0);
            chk1("init_start.rd_start", o_rd_start, 1'b0);
            @(negedge i_s_clk);
        end
        for (int j = 1; j <= blen; j++) begin
            rand_mosi();
            i_init_busy = (c == C_INIT) ? (j < len) : 1'($urandom);
            i_wr_busy   = (c == C_WR)   ? (j < len) : 1'($urandom);
            i_rd_busy   = (c == C_RD)   ? (j < len) : 1'($urandom);
            i_init_ok   = (j == blen) ? ok : 1'($urandom);
            if (j == rd_raise_at) i_rd_req = 1'b1;
            if (shuffle_reqs && (j == 2)) begin
                i_wr_req = 1'($urandom);
                i_rd_req = 1'($urandom);
            end
            exp_mosi = (c == C_INIT) ? i_init_mosi : ((c == C_WR) ? i_wr_mosi : i_rd_mosi);
            #1;
            chk1("bus.cs_n", o_cs_n, 1'b0);
            chk1("bus.mosi", o_mosi, exp_mosi);
            chk3("bus.state", o_3_state, st);
            chk1("bus.init_start", o_init_start, 1'b0);
            chk1("bus.wr_start", o_wr_start, (c == C_WR) && (j == 1));
            chk1("bus.rd_start", o_rd_start, (c == C_RD) && (j == 1));
            chk1("bus.ready", o_ready, 1'b0);
            chk1("bus.error", o_error, 1'b0);
            @(negedge i_s_clk);
        end
        i_init_busy = 1'b0;
        i_wr_busy   = 1'b0;
        i_rd_busy   = 1'b0;
        if (!((c == C_INIT) && !ok)) begin
            for (int g = 0; g < GAP; g++) quiet_cycle("gap", 3'd6, 1'b0, 1'b0);
        end
    endtask

    // From an idle cycle with the given requests: model picks the winner.
    task automatic grant_round(input logic w, input logic r, input int len, input int rd_raise_at,
                               input bit shuffle);
        int exp;
        i_wr_req = w;
        i_rd_req = r;
        quiet_cycle("idle", 3'd3, 1'b1, 1'b0);
        if (w && r) exp = (last_srv == C_RD) ? C_WR : C_RD;
        else        exp = w ? C_WR : C_RD;
        last_srv = exp;
        do_txn(exp, len, 1'b0, rd_raise_at, shuffle);
    endtask

    initial begin
        logic w, r;
        @(negedge i_s_clk);
        apply_reset();
        powerup_check();
        do_txn(C_INIT, 200, 1'b1, 0, 1'b0);

        for (int k = 0; k < 4; k++) grant_round(1'b1, 1'b1, int'($urandom_range(0, 30)), 0, 1'b0);

        for (int k = 0; k < 12; k++) begin
            w = 1'($urandom);
            r = 1'($urandom);
            if (!w && !r) begin
                i_wr_req = 1'b0;
                i_rd_req = 1'b0;
                repeat (1 + ($urandom % 4)) quiet_cycle("idle_none", 3'd3, 1'b1, 1'b0);
            end else begin
                grant_round(w, r, int'($urandom_range(0, 40)), 0, 1'b1);
            end
        end

        // Long writer transfer; reader asks midway and must wait for gap.
        grant_round(1'b1, 1'b0, 4200, 2100, 1'b0);
        grant_round(1'b1, 1'b1, 10, 0, 1'b0);

        // Reset in the middle of a writer grant.
        i_wr_req = 1'b1;
        i_rd_req = 1'b0;
        quiet_cycle("idle", 3'd3, 1'b1, 1'b0);
        rand_mosi();
        i_wr_busy = 1'b1;
        #1;
        chk1("midreset.wr_start", o_wr_start, 1'b1);
        chk1("midreset.cs_before", o_cs_n, 1'b0);
        @(negedge i_s_clk);
        #2;
        apply_reset();
        powerup_check();
        do_txn(C_INIT, int'($urandom_range(0, 50)), 1'b1, 0, 1'b0);
        grant_round(1'b1, 1'b1, int'($urandom_range(0, 20)), 0, 1'b0);

        // Failed init: sticky error, all requests ignored.
        apply_reset();
        powerup_check();
        do_txn(C_INIT, int'($urandom_range(0, 50)), 1'b0, 0, 1'b0);
        for (int k = 0; k < 1000; k++) begin
            i_wr_req    = 1'($urandom);
            i_rd_req    = 1'($urandom);
            i_wr_busy   = 1'($urandom);
            i_init_busy = 1'($urandom);
            i_init_ok   = 1'($urandom);
            quiet_cycle("error", 3'd7, 1'b0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_bus_sequencer.md
Name: sd_bus_sequencer

Overview:
Owns the single SPI link to the SD card and sequences it. It drives power-up dummy clocks, then hands the bus to the init engine until that engine reports done. After init, it arbitrates between the block writer and the block reader, alternating fairly between them.
Each granted client receives a one-cycle start pulse and keeps MOSI/CS until its busy falls, followed by an idle gap of MOSI=1 clocks. Sits between the SPI pads and the init/writer/reader engines.

Parameters:
POWERUP_CLKS, 80, i_s_clk cycles with CS high and MOSI=1 after reset (SD spec ≥74)
GAP_CLKS, 8, idle cycles (CS high, MOSI=1) inserted after every transaction
TIMEOUT_CYCLES, 1048576, watchdog limit per grant (optional feature only)

Ports:
i_s_clk  in  1  SPI bit clock; all logic rising-edge
i_reset  in  1  asynchronous, active-high reset
i_init_busy  in  1  init engine busy
i_init_ok  in  1  init engine success flag, sampled when busy falls
i_init_mosi  in  1  init engine serial out
o_init_start  out  1  one-cycle start pulse to init engine
i_wr_req  in  1  writer has a block ready (level)
i_wr_busy  in  1  writer busy
i_wr_mosi  in  1  writer serial out
o_wr_start  out  1  one-cycle start pulse to writer
i_rd_req  in  1  reader request (level)
i_rd_busy  in  1  reader busy
i_rd_mosi  in  1  reader serial out
o_rd_start  out  1  one-cycle start pulse to reader
o_mosi  out  1  muxed MOSI to card
o_cs_n  out  1  card chip-select, active-low
o_ready  out  1  init complete, bus idle in sIdle
o_error  out  1  sticky error
o_3_state  out  3  current state, debug/LED

Behaviour:
- Reset (async) sets the FSM to sPowerUp and clears all counters. Output reset values: o_mosi=1, o_cs_n=1, all starts=0, o_ready=0, o_error=0, last-served=reader, so the writer wins the first tie.
- State encodings:
  - sPowerUp=0: count POWERUP_CLKS cycles → sInitStart.
  - sInitStart=1: o_init_start=1 for exactly one cycle → sInitRun.
  - sInitRun=2: o_cs_n=0, o_mosi=i_init_mosi. Busy is ignored in the first cycle (arm cycle). When busy=0: i_init_ok=1 → sGap with the init-done flag set; i_init_ok=0 → sError.
  - sIdle=3: o_ready=1. If both requests are set, grant the one not served last. If only one is set, grant it. If none, stay.
  - sGrantWr=4 / sGrantRd=5: corresponding start=1 for one cycle, CS low from this cycle. Then hold (same encoding, arm flag cleared) with o_mosi from that client until its busy=0 after the arm cycle → sGap. Update last-served.
  - sGap=6: CS high, MOSI=1 for GAP_CLKS cycles → sIdle.
  - sError=7: CS high, MOSI=1, o_error=1. Exit only via reset.
- o_mosi is 1 and o_cs_n is 1 in every state other than sInitRun, sGrantWr and sGrantRd; MOSI is never muxed from a non-granted client.
- A request dropped before the grant is ignored. A request dropped after the start pulse does not abort; the grant is still released only when busy falls.
- Busy already low on the cycle after the arm cycle: treated as a zero-length transaction → sGap.
- Gap counter width is clog2(GAP_CLKS+1); power-up counter width is clog2(POWERUP_CLKS+1). Counters are saturating; no wrap.
- Reset mid-transaction: CS deasserts asynchronously and the FSM restarts at sPowerUp; client engines are expected to share i_reset.

Optional Feature:
SD_SEQ_TIMEOUT_EN
- Defined: a 21-bit watchdog counts in sInitRun/sGrantWr/sGrantRd and clears on entry. Reaching TIMEOUT_CYCLES forces sError with CS high.
- Undefined: no watchdog; a hung client holds the bus indefinitely.

Decomposition:
- Shared package/header sd_pkg: the state encodings, default POWERUP_CLKS/GAP_CLKS, and client IDs (INIT=0, WR=1, RD=2).
- One natural sub-module: sd_idle_clock_counter, a loadable down-counter with a done flag, instanced for power-up and gap, and also for the watchdog when enabled.

Test Plan:
- Reset release with all inputs idle → o_cs_n=1 and o_mosi=1 for exactly 80 cycles, then o_init_start high for 1 cycle.
- Init busy for 200 cycles then ok=1 → CS low for those cycles, then 8 gap cycles with CS high, then o_ready=1.
- Init ends with ok=0 → o_error=1 sticky, o_cs_n=1, and wr/rd requests ignored for 1000 cycles.
- i_wr_req and i_rd_req both held high → grants alternate WR, RD, WR, RD, each separated by ≥8 idle cycles. o_mosi equals the granted client's mosi bit-for-bit.
- Writer busy toggles for 4200 cycles with i_rd_req asserted mid-transfer → no o_rd_start until the writer's busy falls plus 8 gap cycles.
- With SD_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, writer busy stuck high → state 7 and o_error=1 at cycle 100 of the grant, CS high.
